// File: rtl/adc_sample_capture_if.sv
// rtl/adc_sample_capture_if.sv - sample stream bundle between capture block and DMA
interface adc_sample_capture_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_sample_capture.sv
// rtl/adc_sample_capture.sv - serial ADC readout into a packetised sample stream
module adc_sample_capture #(
    parameter int DATA_WIDTH = 18,
    parameter int SCK_DIV    = 1,
    parameter int PACKET_LEN = 1024
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 trigger,
    output logic                 sck,
    input  logic                 sdo,
    adc_sample_capture_if.master m_axis,
    output logic                 last,
    input  logic                 clear_overrun,
    output logic                 overrun,
    output logic [15:0]          overrun_count
);
    localparam int DIV_W  = $clog2(SCK_DIV + 1);
    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int BEAT_W = $clog2(PACKET_LEN + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [BEAT_W-1:0]   r_beat;
    logic [BEAT_W-1:0]   w_beat_next;
    logic                r_sck;
    logic                r_tvalid;
    logic                r_tlast;
    logic [31:0]         r_tdata;
    logic                r_last;
    logic                r_overrun;
    logic [15:0]         r_ovr_cnt;
    logic                w_div_done;
    logic                w_bit_last;
    logic                w_shift_en;
    logic                w_sample;
    logic                w_hs;
    logic                w_load;
    logic                w_drop;
    logic                w_trig_ovr;
    logic [1:0]          w_ovr_inc;
    logic [16:0]         w_ovr_sum;

    assign w_div_done   = (r_div_cnt == DIV_W'(SCK_DIV - 1));
    assign w_bit_last   = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign w_shift_next = (r_shift << 1) | DATA_WIDTH'(sdo);
    assign w_hs         = r_tvalid && m_axis.tready;
    // A finished sample may replace a beat that is leaving in the same cycle.
    assign w_load       = w_sample && (!r_tvalid || w_hs);
    assign w_drop       = w_sample && !w_load;
    assign w_trig_ovr   = trigger && (r_state != IDLE);
    assign w_ovr_inc    = {1'b0, w_trig_ovr} + {1'b0, w_drop};
    assign w_ovr_sum    = {1'b0, r_ovr_cnt} + 17'(w_ovr_inc);
    assign w_beat_next  = w_hs ? (r_tlast ? '0 : r_beat + 1'b1) : r_beat;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_sample     = 1'b0;
        case (r_state)
            IDLE: begin
                if (trigger) w_next_state = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (w_div_done) w_next_state = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (w_div_done) begin
                    w_shift_en = 1'b1;
                    if (w_bit_last) begin
                        w_sample     = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = SHIFT_LO;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_sck     <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_beat    <= '0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_tdata   <= '0;
            r_last    <= 1'b0;
            r_overrun <= 1'b0;
            r_ovr_cnt <= '0;
        end else begin
            r_sck     <= (w_next_state == SHIFT_HI);
            r_div_cnt <= (r_state == IDLE || w_div_done) ? '0 : r_div_cnt + 1'b1;
            if (r_state == IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_shift_en) r_shift <= w_shift_next;
            r_beat <= w_beat_next;
            r_last <= w_hs && r_tlast;
            // tlast uses the post-handshake beat index so back-to-back beats frame correctly.
            if (w_load) begin
                r_tdata  <= 32'(w_shift_next);
                r_tvalid <= 1'b1;
                r_tlast  <= (w_beat_next == BEAT_W'(PACKET_LEN - 1));
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
            if (clear_overrun) begin
                r_overrun <= 1'b0;
                r_ovr_cnt <= '0;
            end else if (w_ovr_inc != 2'd0) begin
                r_overrun <= 1'b1;
                r_ovr_cnt <= w_ovr_sum[16] ? 16'hFFFF : w_ovr_sum[15:0];
            end
        end
    end

    assign sck           = r_sck;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign last          = r_last;
    assign overrun       = r_overrun;
    assign overrun_count = r_ovr_cnt;
endmodule

// File: tb/tb_adc_sample_capture.sv
// tb/tb_adc_sample_capture.sv - directed checks of adc_sample_capture over three parameter sets
module tb_adc_sample_capture;
    localparam int DWS [3] = '{18, 18, 4};

    logic        aclk;
    logic        areset;
    logic [2:0]  trig, tready_v, clr, mclr;
    logic [2:0]  sck_v, sdo_v, vld, tl, lst, ovr;
    logic [31:0] td [3];
    logic [15:0] oc [3];
    logic [31:0] word [3];
    int          rises [3] = '{0, 0, 0};
    int          hic [3]   = '{0, 0, 0};
    logic [2:0]  sck_q     = '0;
    int          errors    = 0;
    int          checks    = 0;

    adc_sample_capture_if if_a ();
    adc_sample_capture_if if_b ();
    adc_sample_capture_if if_c ();

    adc_sample_capture u_a (
        .aclk(aclk), .areset(areset), .trigger(trig[0]), .sck(sck_v[0]), .sdo(sdo_v[0]),
        .m_axis(if_a.master), .last(lst[0]), .clear_overrun(clr[0]),
        .overrun(ovr[0]), .overrun_count(oc[0])
    );
    adc_sample_capture #(.DATA_WIDTH(18), .SCK_DIV(2), .PACKET_LEN(4)) u_b (
        .aclk(aclk), .areset(areset), .trigger(trig[1]), .sck(sck_v[1]), .sdo(sdo_v[1]),
        .m_axis(if_b.master), .last(lst[1]), .clear_overrun(clr[1]),
        .overrun(ovr[1]), .overrun_count(oc[1])
    );
    adc_sample_capture #(.DATA_WIDTH(4), .SCK_DIV(1), .PACKET_LEN(1)) u_c (
        .aclk(aclk), .areset(areset), .trigger(trig[2]), .sck(sck_v[2]), .sdo(sdo_v[2]),
        .m_axis(if_c.master), .last(lst[2]), .clear_overrun(clr[2]),
        .overrun(ovr[2]), .overrun_count(oc[2])
    );

    assign if_a.tready = tready_v[0];
    assign if_b.tready = tready_v[1];
    assign if_c.tready = tready_v[2];
    assign vld = {if_c.tvalid, if_b.tvalid, if_a.tvalid};
    assign tl  = {if_c.tlast, if_b.tlast, if_a.tlast};
    assign td[0] = if_a.tdata;
    assign td[1] = if_b.tdata;
    assign td[2] = if_c.tdata;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ADC model: presents bit (DW - n) while the n-th SCK high phase is in progress.
    always @(negedge aclk) begin
        for (int i = 0; i < 3; i++) begin
            if (mclr[i]) begin
                rises[i] = 0;
                hic[i]   = 0;
            end else begin
                if (sck_v[i]) hic[i]++;
                if (sck_v[i] && !sck_q[i]) rises[i]++;
            end
            sck_q[i] = sck_v[i];
        end
    end

    always_comb begin
        sdo_v = '0;
        for (int i = 0; i < 3; i++) begin
            if (rises[i] >= 1 && rises[i] <= DWS[i]) sdo_v[i] = word[i][DWS[i] - rises[i]];
        end
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts a conversion on DUT d; returns edges from trigger edge until tvalid is seen.
    task automatic conv(input int d, input logic [31:0] w, input int trig2_at, output int lat);
        word[d] = w;
        mclr[d] = 1'b1;
        trig[d] = 1'b1;
        tick;
        mclr[d] = 1'b0;
        trig[d] = 1'b0;
        lat = 0;
        while (!vld[d] && lat < 400) begin
            trig[d] = (lat + 1 == trig2_at);
            tick;
            lat++;
        end
        trig[d] = 1'b0;
    endtask

    initial begin
        int   lat;
        int   beats;
        int   lastcnt;
        logic prev;
        logic seen;

        areset   = 1'b1;
        trig     = '0;
        tready_v = '0;
        clr      = '0;
        mclr     = '0;
        word[0]  = '0;
        word[1]  = '0;
        word[2]  = '0;
        tick;
        tick;
        areset = 1'b0;
        chk("rst_sck", 32'(sck_v[0]), 0);
        chk("rst_tvalid", 32'(vld[0]), 0);
        chk("rst_tlast", 32'(tl[0]), 0);
        chk("rst_tdata", td[0], 0);
        chk("rst_last", 32'(lst[0]), 0);
        chk("rst_overrun", 32'(ovr[0]), 0);
        chk("rst_count", 32'(oc[0]), 0);

        // single conversion, defaults
        tready_v = 3'b111;
        conv(0, 32'h2A5A5, -1, lat);
        chk("single_latency", lat, 36);
        chk("single_tvalid", 32'(vld[0]), 1);
        chk("single_tdata", td[0], 32'h0002A5A5);
        chk("single_tlast", 32'(tl[0]), 0);
        chk("single_sck_pulses", rises[0], 18);
        chk("single_sck_high_cycles", hic[0], 18);
        tick;
        chk("single_after_hs_tvalid", 32'(vld[0]), 0);
        chk("single_after_hs_last", 32'(lst[0]), 0);
        chk("single_after_sck", 32'(sck_v[0]), 0);

        // packet framing, PACKET_LEN=4 SCK_DIV=2
        beats   = 0;
        lastcnt = 0;
        prev    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            word[1] = 32'h10000 + i * 32'h1111;
            mclr[1] = 1'b1;
            trig[1] = 1'b1;
            tick;
            mclr[1] = 1'b0;
            trig[1] = 1'b0;
            for (int j = 0; j < 99; j++) begin
                tick;
                if (lst[1] || prev) chk("frame_last_align", 32'(lst[1]), 32'(prev));
                if (lst[1]) lastcnt++;
                if (vld[1]) begin
                    chk("frame_tlast", 32'(tl[1]), 32'(i == 3 || i == 7));
                    chk("frame_tdata", td[1], 32'h10000 + i * 32'h1111);
                    beats++;
                end
                prev = vld[1] && tready_v[1] && tl[1];
            end
        end
        chk("frame_beats", beats, 8);
        chk("frame_last_pulses", lastcnt, 2);

        // backpressure and overrun
        tready_v[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            word[0] = (i == 0) ? 32'h3FFFF : 32'(i);
            mclr[0] = 1'b1;
            trig[0] = 1'b1;
            tick;
            mclr[0] = 1'b0;
            trig[0] = 1'b0;
            repeat (49) tick;
            chk("bp_tvalid_held", 32'(vld[0]), 1);
            chk("bp_tdata_held", td[0], 32'h0003FFFF);
            chk("bp_count", 32'(oc[0]), i);
            chk("bp_overrun", 32'(ovr[0]), 32'(i > 0));
        end
        tready_v[0] = 1'b1;
        tick;
        chk("bp_release_tvalid", 32'(vld[0]), 0);
        seen = 1'b0;
        repeat (5) begin
            tick;
            seen |= vld[0];
        end
        chk("bp_single_beat", 32'(seen), 0);
        clr[0] = 1'b1;
        tick;
        clr[0] = 1'b0;
        chk("clear_overrun_flag", 32'(ovr[0]), 0);
        chk("clear_overrun_count", 32'(oc[0]), 0);

        // trigger during shift
        conv(0, 32'h15555, 10, lat);
        chk("busy_trig_latency", lat, 36);
        chk("busy_trig_tdata", td[0], 32'h00015555);
        chk("busy_trig_count", 32'(oc[0]), 1);
        tick;
        seen = 1'b0;
        repeat (40) begin
            tick;
            seen |= vld[0];
        end
        chk("busy_trig_no_extra", 32'(seen), 0);
        clr[0] = 1'b1;
        tick;
        clr[0] = 1'b0;

        // reset mid-shift; B gets one beat first so its beat counter is non-zero
        conv(1, 32'h00042, -1, lat);
        chk("b_pre_latency", lat, 72);
        tick;
        word[0] = 32'h3C3C3;
        mclr[0] = 1'b1;
        trig[0] = 1'b1;
        tick;
        mclr[0] = 1'b0;
        trig[0] = 1'b0;
        repeat (4) tick;
        trig[0] = 1'b1;
        tick;
        trig[0] = 1'b0;
        repeat (10) tick;
        chk("mid_sck_high", 32'(sck_v[0]), 1);
        chk("mid_count", 32'(oc[0]), 1);
        areset = 1'b1;
        tick;
        areset = 1'b0;
        chk("mid_rst_sck", 32'(sck_v[0]), 0);
        chk("mid_rst_tvalid", 32'(vld[0]), 0);
        chk("mid_rst_overrun", 32'(ovr[0]), 0);
        chk("mid_rst_count", 32'(oc[0]), 0);
        seen = 1'b0;
        repeat (40) begin
            tick;
            seen |= vld[0];
        end
        chk("mid_no_partial", 32'(seen), 0);
        conv(0, 32'h0ABCD, -1, lat);
        chk("post_rst_latency", lat, 36);
        chk("post_rst_tdata", td[0], 32'h0000ABCD);
        tick;
        for (int k = 0; k < 4; k++) begin
            conv(1, 32'h200 + k, -1, lat);
            chk("post_rst_b_tdata", td[1], 32'h200 + k);
            chk("post_rst_b_tlast", 32'(tl[1]), 32'(k == 3));
            tick;
        end

        // PACKET_LEN=1
        for (int k = 0; k < 3; k++) begin
            logic [31:0] w;
            w = (k == 0) ? 32'hA : (k == 1) ? 32'h5 : 32'hF;
            conv(2, w, -1, lat);
            chk("pl1_latency", lat, 8);
            chk("pl1_tdata", td[2], w);
            chk("pl1_tlast", 32'(tl[2]), 1);
            tick;
            chk("pl1_last_pulse", 32'(lst[2]), 1);
            tick;
            chk("pl1_last_width", 32'(lst[2]), 0);
        end

        // saturation
        trig[0] = 1'b1;
        repeat (68000) tick;
        chk("sat_count", 32'(oc[0]), 32'hFFFF);
        chk("sat_overrun", 32'(ovr[0]), 1);
        lat = 0;
        while (!sck_v[0] && lat < 100) begin
            tick;
            lat++;
        end
        chk("sat_sck_found", 32'(sck_v[0]), 1);
        clr[0] = 1'b1;
        tick;
        clr[0]  = 1'b0;
        trig[0] = 1'b0;
        chk("clear_precedence_count", 32'(oc[0]), 0);
        chk("clear_precedence_flag", 32'(ovr[0]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
